// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and tag type for the DCT MAC sequencer
package dct_pkg;

  localparam int DCT_TAPS     = 8;
  localparam int DCT_MULT_LAT = 1;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } mac_tag_t;

endpackage

// File: rtl/dct_mac_tag_pipe.sv
// rtl/dct_mac_tag_pipe.sv - tag shift register tracking samples through the multiplier pipeline
module dct_mac_tag_pipe
  import dct_pkg::*;
#(
  parameter int MULT_LAT = DCT_MULT_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ena,
  input  mac_tag_t tag_in,
  output mac_tag_t tag_out,
  output logic     any_last
);

  mac_tag_t            stage_q [MULT_LAT];
  mac_tag_t            stage_d [MULT_LAT];
  logic [MULT_LAT-1:0] stage_last;

  always_comb begin
    stage_d = stage_q;
    if (ena) begin
      stage_d[0] = tag_in;
      for (int i = 1; i < MULT_LAT; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // Any stage carrying a vector's final tap means a result is still on its way.
  always_comb begin
    stage_last = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      stage_last[i] = stage_q[i].vld & stage_q[i].last;
    end
  end

  assign tag_out  = stage_q[MULT_LAT-1];
  assign any_last = |stage_last;

endmodule

// File: rtl/dct_mac_sequencer.sv
// rtl/dct_mac_sequencer.sv - control sequencer for one dct_unit multiply-accumulate datapath
module dct_mac_sequencer
  import dct_pkg::*;
#(
  parameter int  N_TAPS   = DCT_TAPS,
  parameter int  MULT_LAT = DCT_MULT_LAT,
  localparam int TW       = $clog2(N_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic [TW-1:0] coef_sel,
  output logic          mult_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          res_latch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          realign
);

  localparam logic [TW-1:0] LAST_TAP = TW'(N_TAPS - 1);

  logic [TW-1:0] tap_cnt_q, tap_cnt_d;
  logic          latch_pend_q, latch_pend_d;
  logic          out_valid_q, out_valid_d;

  logic [TW-1:0] tap;
  logic          is_last_tap;
  logic          accept;
  logic          any_last;
  logic          last_in_flight;
  mac_tag_t      tag_in;
  mac_tag_t      tag_out;

  assign tap         = in_sof ? '0 : tap_cnt_q;
  assign is_last_tap = (tap == LAST_TAP);

  // Only the final tap is held back, so the result register is never overwritten
  // while earlier taps of the next vector keep streaming into the accumulator.
  assign last_in_flight = any_last | latch_pend_q;
  assign in_ready = ena & ~(is_last_tap & (last_in_flight | (out_valid_q & ~out_ready)));
  assign accept   = in_valid & in_ready;

  assign coef_sel  = tap;
  assign mult_en   = accept;
  assign realign   = accept & in_sof & (tap_cnt_q != '0);
  assign acc_en    = ena & tag_out.vld;
  assign acc_clr   = ena & tag_out.vld & tag_out.first;
  assign res_latch = ena & latch_pend_q;
  assign out_valid = out_valid_q;

  always_comb begin
    tag_in.vld   = accept;
    tag_in.first = (tap == '0);
    tag_in.last  = is_last_tap;
  end

  dct_mac_tag_pipe #(
    .MULT_LAT (MULT_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .any_last (any_last)
  );

  always_comb begin
    tap_cnt_d    = tap_cnt_q;
    latch_pend_d = latch_pend_q;
    out_valid_d  = out_valid_q;
    if (ena) begin
      if (accept) begin
        tap_cnt_d = is_last_tap ? '0 : tap + TW'(1);
      end
      latch_pend_d = tag_out.vld & tag_out.last;
      // A new latch wins over a same-edge delivery: fresh data is in the register.
      if (res_latch) begin
        out_valid_d = 1'b1;
      end else if (out_valid_q & out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt_q    <= '0;
      latch_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      tap_cnt_q    <= tap_cnt_d;
      latch_pend_q <= latch_pend_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule
